// File: rtl/dma_rx_axis_arbiter.sv
// Packet-atomic round-robin arbiter merging C_NUM_PORTS AXI4-Stream sources onto the single
// DMA S_AXIS ingress, with optional TUSER src_port stamping and per-input packet counters.
module dma_rx_axis_arbiter #(
   parameter int unsigned C_NUM_PORTS    = 4,
   parameter int unsigned C_DATA_WIDTH   = 256,
   parameter int unsigned C_TUSER_WIDTH  = 128,
   parameter bit          C_STAMP_SRC    = 1'b1,
   parameter logic [63:0] C_SRC_PORT_MAP = 64'h0000000040100401
) (
   input  logic                                  AXIS_ACLK,
   input  logic                                  AXIS_ARESETN,
   input  logic [C_NUM_PORTS*C_DATA_WIDTH-1:0]   S_AXIS_TDATA,
   input  logic [C_NUM_PORTS*C_DATA_WIDTH/8-1:0] S_AXIS_TSTRB,
   input  logic [C_NUM_PORTS*C_TUSER_WIDTH-1:0]  S_AXIS_TUSER,
   input  logic [C_NUM_PORTS-1:0]                S_AXIS_TVALID,
   output logic [C_NUM_PORTS-1:0]                S_AXIS_TREADY,
   input  logic [C_NUM_PORTS-1:0]                S_AXIS_TLAST,
   output logic [C_DATA_WIDTH-1:0]               M_AXIS_TDATA,
   output logic [C_DATA_WIDTH/8-1:0]             M_AXIS_TSTRB,
   output logic [C_TUSER_WIDTH-1:0]              M_AXIS_TUSER,
   output logic                                  M_AXIS_TVALID,
   input  logic                                  M_AXIS_TREADY,
   output logic                                  M_AXIS_TLAST,
   input  logic [C_NUM_PORTS-1:0]                port_en,
   input  logic                                  clear_counters,
   output logic [C_NUM_PORTS*32-1:0]             pkt_count,
   output logic [2:0]                            grant_idx,
   output logic                                  busy
);

   localparam int unsigned SW = C_DATA_WIDTH / 8;

   typedef enum logic [0:0] {StIdle, StPkt} state_e;
   typedef logic [C_NUM_PORTS-1:0] req_t;

   state_e      state_q, state_d;
   logic [2:0]  grant_q, grant_d;
   logic [2:0]  rr_q, rr_d;
   logic [31:0] cnt_q [C_NUM_PORTS];
   logic [31:0] cnt_d [C_NUM_PORTS];
   req_t        req, req_rot;
   logic [3:0]  sel;
   logic        found;
   logic        fire;

   assign req     = S_AXIS_TVALID & port_en;
   // Rotate so bit 0 corresponds to rr_q; lowest set bit is then the round-robin winner.
   assign req_rot = req_t'({req, req} >> rr_q);

   always_comb begin
      found = 1'b0;
      sel   = '0;
      for (int k = C_NUM_PORTS - 1; k >= 0; k--) begin
         if (req_rot[k]) begin
            found = 1'b1;
            sel   = {1'b0, rr_q} + 4'(k);
         end
      end
      if (sel >= 4'(C_NUM_PORTS)) sel = sel - 4'(C_NUM_PORTS);
   end

   always_comb begin
      M_AXIS_TDATA  = '0;
      M_AXIS_TSTRB  = '0;
      M_AXIS_TUSER  = '0;
      M_AXIS_TVALID = 1'b0;
      M_AXIS_TLAST  = 1'b0;
      S_AXIS_TREADY = '0;
      if (state_q == StPkt) begin
         for (int i = 0; i < C_NUM_PORTS; i++) begin
            if (grant_q == 3'(i)) begin
               M_AXIS_TDATA     = S_AXIS_TDATA[i*C_DATA_WIDTH +: C_DATA_WIDTH];
               M_AXIS_TSTRB     = S_AXIS_TSTRB[i*SW +: SW];
               M_AXIS_TUSER     = S_AXIS_TUSER[i*C_TUSER_WIDTH +: C_TUSER_WIDTH];
               M_AXIS_TVALID    = S_AXIS_TVALID[i];
               M_AXIS_TLAST     = S_AXIS_TLAST[i];
               S_AXIS_TREADY[i] = M_AXIS_TREADY;
               if (C_STAMP_SRC) M_AXIS_TUSER[23:16] = C_SRC_PORT_MAP[8*i +: 8];
            end
         end
      end
   end

   assign fire = (state_q == StPkt) && M_AXIS_TVALID && M_AXIS_TREADY && M_AXIS_TLAST;

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      rr_d    = rr_q;
      unique case (state_q)
         StIdle: begin
            if (found) begin
               grant_d = sel[2:0];
               state_d = StPkt;
            end
         end
         StPkt: begin
            if (fire) begin
               state_d = StIdle;
               rr_d    = (grant_q == 3'(C_NUM_PORTS - 1)) ? 3'd0 : grant_q + 3'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Clear has priority over a same-cycle packet completion.
   always_comb begin
      for (int i = 0; i < C_NUM_PORTS; i++) begin
         cnt_d[i] = cnt_q[i];
         if (clear_counters)                     cnt_d[i] = '0;
         else if (fire && (grant_q == 3'(i)))    cnt_d[i] = cnt_q[i] + 32'd1;
      end
   end

   always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
      if (!AXIS_ARESETN) begin
         state_q <= StIdle;
         grant_q <= '0;
         rr_q    <= '0;
         for (int i = 0; i < C_NUM_PORTS; i++) cnt_q[i] <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         rr_q    <= rr_d;
         for (int i = 0; i < C_NUM_PORTS; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   always_comb begin
      for (int i = 0; i < C_NUM_PORTS; i++) pkt_count[32*i +: 32] = cnt_q[i];
   end

   assign grant_idx = grant_q;
   assign busy      = (state_q == StPkt);

endmodule
